// File: rtl/mem_arbiter.sv
// Purpose: two-port (core, debug) arbiter in front of a single-ported data memory.
// Latency: grant one cycle after request; read data/rvalid one cycle after grant.
// Backpressure: a requester holds its request until it sees gnt; grants are >= 2 cycles apart.
// Build option: define MEM_ARB_RR_EN for round-robin tie-break (default: core wins ties).
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    // core port
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    // debug / loader port
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    // data memory
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_CORE = 2'd1,
        SERVE_DBG  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // Set in the IDLE cycle right after a port's own SERVE, where its
    // still-asserted request must not be taken as a new one.
    logic        just_core_q, just_core_d;
    logic        just_dbg_q,  just_dbg_d;
    logic        core_rvalid_q, core_rvalid_d;
    logic        dbg_rvalid_q,  dbg_rvalid_d;
    logic [31:0] core_rdata_q,  core_rdata_d;
    logic [31:0] dbg_rdata_q,   dbg_rdata_d;
`ifdef MEM_ARB_RR_EN
    // 1: debug was served most recently, 0: core was.
    logic        last_dbg_q, last_dbg_d;
`endif

    logic core_elig;
    logic dbg_elig;

    // Next-state selection: one-cycle SERVE states, tie-break in IDLE.
    always_comb begin
        state_d   = state_q;
        core_elig = core_req && !just_core_q;
        dbg_elig  = dbg_req && !just_dbg_q;
        case (state_q)
            IDLE: begin
                if (core_elig && dbg_elig) begin
`ifdef MEM_ARB_RR_EN
                    state_d = last_dbg_q ? SERVE_CORE : SERVE_DBG;
`else
                    state_d = SERVE_CORE;
`endif
                end else if (core_elig) begin
                    state_d = SERVE_CORE;
                end else if (dbg_elig) begin
                    state_d = SERVE_DBG;
                end
            end
            SERVE_CORE: state_d = IDLE;
            SERVE_DBG:  state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Bookkeeping for the next cycle: served-port flags, read capture, RR pointer.
    always_comb begin
        just_core_d   = (state_q == SERVE_CORE);
        just_dbg_d    = (state_q == SERVE_DBG);
        core_rvalid_d = (state_q == SERVE_CORE) && !core_we;
        dbg_rvalid_d  = (state_q == SERVE_DBG) && !dbg_we;
        core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
        dbg_rdata_d   = dbg_rvalid_d  ? mem_rdata : dbg_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_dbg_d = last_dbg_q;
        if (state_q == IDLE && state_d == SERVE_CORE) begin
            last_dbg_d = 1'b0;
        end else if (state_q == IDLE && state_d == SERVE_DBG) begin
            last_dbg_d = 1'b1;
        end
`endif
    end

    // State and read-return registers; reset drops any pending rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            just_core_q   <= 1'b0;
            just_dbg_q    <= 1'b0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= 32'd0;
            dbg_rdata_q   <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_dbg_q    <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            just_core_q   <= just_core_d;
            just_dbg_q    <= just_dbg_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_dbg_q    <= last_dbg_d;
`endif
        end
    end

    // Grants and memory-side mux decoded from the current state; IDLE drives zeros.
    always_comb begin
        core_gnt  = 1'b0;
        dbg_gnt   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state_q)
            SERVE_CORE: begin
                core_gnt  = 1'b1;
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end
            SERVE_DBG: begin
                dbg_gnt   = 1'b1;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: begin
                core_gnt = 1'b0;
            end
        endcase
    end

    assign core_rvalid = core_rvalid_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign core_stall  = core_req && !core_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Tie-break expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic        core_gnt, core_rvalid, core_stall;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // bench-side preload path into the memory model
    logic        tb_ld;
    logic [31:0] tb_addr, tb_dat;
    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;
    logic core_first;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (tb_ld) mem[tb_addr[7:2]] <= tb_dat;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'd0; core_wdata = 32'd0;
        dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = 32'd0; dbg_wdata  = 32'd0;
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        core_first = 1'b0;
`else
        core_first = 1'b1;
`endif
        reset = 1'b1;
        idle_inputs();
        tb_ld = 1'b1; tb_addr = 32'h10; tb_dat = 32'hDEADBEEF;
        step();
        tb_ld = 1'b0;
        step();

        // ---- reset state ----
        #1;
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_core_rvalid", core_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        step();
        reset = 1'b0;

        // ---- idle for 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_mem_we", mem_we, 0);
            chk("idle_mem_addr", mem_addr, 0);
            chk("idle_core_gnt", core_gnt, 0);
            chk("idle_dbg_gnt", dbg_gnt, 0);
            step();
        end

        // ---- core-only read of 0x10 ----
        core_req = 1'b1; core_addr = 32'h10;
        #1;
        chk("rd_c0_stall", core_stall, 1);
        chk("rd_c0_gnt", core_gnt, 0);
        step(); #1;
        chk("rd_c1_gnt", core_gnt, 1);
        chk("rd_c1_stall", core_stall, 0);
        chk("rd_c1_mem_addr", mem_addr, 32'h10);
        chk("rd_c1_mem_we", mem_we, 0);
        chk("rd_c1_rvalid", core_rvalid, 0);
        step();
        core_req = 1'b0; core_addr = 32'd0;
        #1;
        chk("rd_c2_rvalid", core_rvalid, 1);
        chk("rd_c2_rdata", core_rdata, 32'hDEADBEEF);
        chk("rd_c2_gnt", core_gnt, 0);
        chk("rd_c2_stall", core_stall, 0);
        step(); #1;
        chk("rd_c3_rvalid", core_rvalid, 0);

        // ---- debug write 0x12345678 to 0x20 ----
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
        #1;
        chk("wr_c0_gnt", dbg_gnt, 0);
        chk("wr_c0_mem_we", mem_we, 0);
        step(); #1;
        chk("wr_c1_dbg_gnt", dbg_gnt, 1);
        chk("wr_c1_core_gnt", core_gnt, 0);
        chk("wr_c1_mem_we", mem_we, 1);
        chk("wr_c1_mem_addr", mem_addr, 32'h20);
        chk("wr_c1_mem_wdata", mem_wdata, 32'h12345678);
        chk("wr_c1_rvalid", dbg_rvalid, 0);
        step();
        idle_inputs();
        #1;
        chk("wr_c2_mem_we", mem_we, 0);
        chk("wr_c2_rvalid", dbg_rvalid, 0);
        step(); #1;
        chk("wr_c3_rvalid", dbg_rvalid, 0);

        // ---- core reads back 0x20 ----
        core_req = 1'b1; core_addr = 32'h20;
        step(); #1;
        chk("rb_c1_gnt", core_gnt, 1);
        step();
        core_req = 1'b0; core_addr = 32'd0;
        #1;
        chk("rb_c2_rvalid", core_rvalid, 1);
        chk("rb_c2_rdata", core_rdata, 32'h12345678);
        chk("rb_dbg_rdata_untouched", dbg_rdata, 0);
        step(); step(); #1;
        chk("rb_rdata_hold", core_rdata, 32'h12345678);

        // ---- tie after core was last served: RR picks dbg, fixed picks core ----
        core_req = 1'b1; core_addr = 32'h10;
        dbg_req  = 1'b1; dbg_addr  = 32'h20;
        step(); #1;
        chk("tie_c1_core_gnt", core_gnt, {31'd0, core_first});
        chk("tie_c1_dbg_gnt", dbg_gnt, {31'd0, !core_first});
        step();
        if (core_first) core_req = 1'b0;
        else dbg_req = 1'b0;
        #1;
        chk("tie_c2_core_gnt", core_gnt, 0);
        chk("tie_c2_dbg_gnt", dbg_gnt, 0);
        chk("tie_c2_core_rvalid", core_rvalid, {31'd0, core_first});
        step(); #1;
        chk("tie_c3_core_gnt", core_gnt, {31'd0, !core_first});
        chk("tie_c3_dbg_gnt", dbg_gnt, {31'd0, core_first});
        step();
        idle_inputs();
        step(); step();

        // ---- fresh reset, then both request continuously ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        core_req = 1'b1; core_addr = 32'h10;
        dbg_req  = 1'b1; dbg_addr  = 32'h20;
        #1;
        chk("cont_c0_stall", core_stall, 1);
        for (int c = 1; c <= 8; c++) begin
            step(); #1;
            chk("cont_core_gnt", core_gnt, {31'd0, (c % 4) == 1});
            chk("cont_dbg_gnt", dbg_gnt, {31'd0, (c % 4) == 3});
            chk("cont_gnt_exclusive", core_gnt & dbg_gnt, 0);
            chk("cont_core_rvalid", core_rvalid, {31'd0, (c % 4) == 2});
            chk("cont_dbg_rvalid", dbg_rvalid, {31'd0, (c % 4) == 0});
            if (c == 4) chk("cont_dbg_rdata", dbg_rdata, 32'h12345678);
        end
        idle_inputs();
        step(); step();

        // ---- reset during SERVE_CORE of a read ----
        core_req = 1'b1; core_addr = 32'h10;
        step(); #1;
        chk("mrst_c1_gnt", core_gnt, 1);
        reset = 1'b1;
        step();
        core_req = 1'b0; core_addr = 32'd0;
        #1;
        chk("mrst_core_rvalid", core_rvalid, 0);
        chk("mrst_dbg_rvalid", dbg_rvalid, 0);
        chk("mrst_core_gnt", core_gnt, 0);
        chk("mrst_dbg_gnt", dbg_gnt, 0);
        chk("mrst_mem_we", mem_we, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_mem_wdata", mem_wdata, 0);
        chk("mrst_core_rdata", core_rdata, 0);
        reset = 1'b0;
        step();

        // ---- write in SERVE_DBG still commits under reset ----
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'hA5A55A5A;
        step(); #1;
        chk("wrst_c1_gnt", dbg_gnt, 1);
        reset = 1'b1;
        step();
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("wrst_mem_we", mem_we, 0);
        chk("wrst_dbg_rvalid", dbg_rvalid, 0);
        step();
        core_req = 1'b1; core_addr = 32'h30;
        step(); #1;
        chk("wrst_rb_gnt", core_gnt, 1);
        step();
        core_req = 1'b0; core_addr = 32'd0;
        #1;
        chk("wrst_rb_rvalid", core_rvalid, 1);
        chk("wrst_rb_rdata", core_rdata, 32'hA5A55A5A);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
